// File: rtl/sha_compare_monitor.sv
// Trigger generator and result checker for the HLS-vs-RTL SHA256 comparison:
// pulses both engines, captures each first digest and its latency, and publishes a status word.
module sha_compare_monitor #(
    parameter int TRIG_BIT = 26,
    parameter int TIMEOUT  = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [29:0]  cnt_in,
    output logic         trig_out,
    output logic         busy,
    input  logic         sha0_ready,
    input  logic [255:0] sha0_value,
    input  logic         sha1_ready,
    input  logic [255:0] sha1_value,
    output logic [31:0]  result_out
);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT, CMP} state_t;

    localparam logic [9:0] TIMEOUT_L = 10'(TIMEOUT);

    state_t       state_q;
    logic         prev_q;
    logic         trig_q;
    logic         busy_q;
    logic         got0_q;
    logic         got1_q;
    logic         tout_q;
    logic [9:0]   lat_q;
    logic [7:0]   lat0_q;
    logic [7:0]   lat1_q;
    logic [255:0] dig0_q;
    logic [255:0] dig1_q;
    logic [31:0]  result_q;

    logic         rise;
    logic         cap0;
    logic         cap1;
    logic         both_done;
    logic         match;
    logic [7:0]   lat_sat;
    logic [5:0]   run_nxt;
    logic [7:0]   fail_nxt;
    logic         unused_cnt;

    assign rise      = cnt_in[TRIG_BIT] & ~prev_q;
    assign cap0      = (state_q == WAIT) && sha0_ready && !got0_q;
    assign cap1      = (state_q == WAIT) && sha1_ready && !got1_q;
    assign both_done = (got0_q | cap0) & (got1_q | cap1);
    assign lat_sat   = (lat_q > 10'd255) ? 8'hFF : lat_q[7:0];
    assign match     = !tout_q && (dig0_q == dig1_q);
    assign run_nxt   = result_q[29:24] + 6'd1;
    assign fail_nxt  = (match || result_q[23:16] == 8'hFF) ? result_q[23:16]
                                                          : result_q[23:16] + 8'd1;
    // Only the trigger bit of the heartbeat matters here.
    assign unused_cnt = ^cnt_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prev_q   <= 1'b1;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            got0_q   <= 1'b0;
            got1_q   <= 1'b0;
            tout_q   <= 1'b0;
            lat_q    <= '0;
            lat0_q   <= '0;
            lat1_q   <= '0;
            dig0_q   <= '0;
            dig1_q   <= '0;
            result_q <= '0;
        end else begin
            prev_q <= cnt_in[TRIG_BIT];
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= TRIG;
                    end
                end
                TRIG: begin
                    // Latencies default to 0xFF so an engine that never answers reports it.
                    trig_q  <= 1'b0;
                    lat_q   <= 10'd1;
                    got0_q  <= 1'b0;
                    got1_q  <= 1'b0;
                    tout_q  <= 1'b0;
                    lat0_q  <= 8'hFF;
                    lat1_q  <= 8'hFF;
                    state_q <= WAIT;
                end
                WAIT: begin
                    lat_q <= lat_q + 10'd1;
                    if (cap0) begin
                        dig0_q <= sha0_value;
                        lat0_q <= lat_sat;
                        got0_q <= 1'b1;
                    end
                    if (cap1) begin
                        dig1_q <= sha1_value;
                        lat1_q <= lat_sat;
                        got1_q <= 1'b1;
                    end
                    if (both_done) begin
                        state_q <= CMP;
                    end else if (lat_q == TIMEOUT_L) begin
                        tout_q  <= 1'b1;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    result_q <= {match, tout_q, run_nxt, fail_nxt, lat0_q, lat1_q};
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trig_out   = trig_q;
    assign busy       = busy_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_sha_compare_monitor.sv
// Scoreboard bench for sha_compare_monitor: a run-level model predicts each status word,
// and a monitor compares it whenever busy falls.
module tb_sha_compare_monitor;

    localparam int TB_TRIG = 26;
    localparam int TO      = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [29:0]  cnt_in;
    logic         trig_out;
    logic         busy;
    logic         sha0_ready;
    logic [255:0] sha0_value;
    logic         sha1_ready;
    logic [255:0] sha1_value;
    logic [31:0]  result_out;

    int total = 0;
    int bad   = 0;
    int m_runs  = 0;
    int m_fails = 0;
    logic [31:0] exp_q[$];

    sha_compare_monitor #(.TRIG_BIT(TB_TRIG), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_in     (cnt_in),
        .trig_out   (trig_out),
        .busy       (busy),
        .sha0_ready (sha0_ready),
        .sha0_value (sha0_value),
        .sha1_ready (sha1_ready),
        .sha1_value (sha1_value),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_bit(input logic b);
        cnt_in = 30'($urandom);
        cnt_in[TB_TRIG] = b;
    endtask

    // Run-level reference: what the status word must say after one run.
    task automatic model_run(input int k0, input int k1, input logic [255:0] v0,
                             input logic [255:0] v1, output logic [31:0] e, output int expc);
        bit ok0, ok1, to, mt;
        int l0, l1;
        ok0 = (k0 >= 1 && k0 <= TO);
        ok1 = (k1 >= 1 && k1 <= TO);
        to  = !(ok0 && ok1);
        mt  = !to && (v0 == v1);
        m_runs = (m_runs + 1) % 64;
        if (!mt && m_fails < 255) m_fails++;
        l0 = ok0 ? ((k0 > 255) ? 255 : k0) : 255;
        l1 = ok1 ? ((k1 > 255) ? 255 : k1) : 255;
        e = {mt, to, 6'(m_runs), 8'(m_fails), 8'(l0), 8'(l1)};
        expc = to ? TO + 2 : ((k0 > k1) ? k0 : k1) + 2;
    endtask

    task automatic do_run(input int k0, input int k1, input logic [255:0] v0,
                          input logic [255:0] v1, input int dupk, input logic [255:0] dupv,
                          input bit noise, input bit rebounce);
        logic [31:0] e;
        int expc, c;
        bit seen;
        @(negedge clk);
        set_bit(1'b0);
        repeat (2) @(negedge clk);
        set_bit(1'b1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (trig_out) begin
                seen = 1;
                break;
            end
        end
        chk("trig_seen", seen, 1);
        if (!seen) return;
        model_run(k0, k1, v0, v1, e, expc);
        exp_q.push_back(e);
        if (noise) begin
            sha0_ready = 1'b1; sha0_value = rand256();
            sha1_ready = 1'b1; sha1_value = rand256();
        end
        for (c = 1; c <= TO + 20; c++) begin
            @(negedge clk);
            if (!busy) break;
            sha0_ready = (c == k0) || (c == dupk);
            sha0_value = (c == k0) ? v0 : (c == dupk) ? dupv : rand256();
            sha1_ready = (c == k1);
            sha1_value = (c == k1) ? v1 : rand256();
            if (rebounce && c == 3) set_bit(1'b0);
            if (rebounce && c == 5) set_bit(1'b1);
        end
        sha0_ready = 1'b0;
        sha1_ready = 1'b0;
        chk("busy_len", c, expc);
    endtask

    // Monitor: every falling edge of busy presents one status word.
    initial begin
        bit bprev;
        int trig_since;
        logic [31:0] e;
        bprev = 0;
        trig_since = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bprev = 0;
                trig_since = 0;
            end else begin
                if (trig_out) trig_since++;
                if (bprev && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", result_out, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", result_out, e);
                        chk("trigs_per_run", trig_since, 1);
                    end
                    trig_since = 0;
                end
                bprev = busy;
            end
        end
    end

    initial begin
        logic [255:0] v, w;
        int k0, k1, n;
        rst_n = 1'b0;
        set_bit(1'b1);
        sha0_ready = 1'b0; sha0_value = '0;
        sha1_ready = 1'b0; sha1_value = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {trig_out, busy, result_out}, 0);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (trig_out) n++;
        end
        chk("no_trig_high_at_release", n, 0);

        v = rand256();
        do_run(65, 70, v, v, 0, '0, 0, 0);
        chk("match_word", result_out, 32'h8100_4146);
        do_run(65, 70, v, v ^ 256'd1, 0, '0, 0, 0);
        chk("mismatch_word", result_out, 32'h0201_4146);
        do_run(10, 0, v, v, 0, '0, 0, 0);
        chk("timeout_word", result_out, 32'h4302_0AFF);

        w = rand256();
        do_run(5, 5, v, v, 6, w, 1, 0);
        do_run(5, 9, v, v, 6, w, 0, 0);
        do_run(3, TO, v, v, 0, '0, 0, 0);
        do_run(3, TO + 1, v, v, 0, '0, 0, 0);
        do_run(30, 40, v, v, 0, '0, 1, 1);

        for (int i = 0; i < 40; i++) begin
            k0 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 5));
            k1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 5));
            v = rand256();
            w = $urandom_range(0, 1) ? v : v ^ (256'd1 << $urandom_range(0, 255));
            do_run(k0, k1, v, w, 0, '0, bit'($urandom_range(0, 1)), 0);
        end

        for (int i = 0; i < 300; i++) begin
            v = rand256();
            do_run(1, 2, v, ~v, 0, '0, 0, 0);
        end
        chk("fail_saturated", result_out[23:16], 8'hFF);

        // Abandon a run mid-WAIT with the heartbeat bit held high.
        @(negedge clk);
        set_bit(1'b0);
        repeat (2) @(negedge clk);
        set_bit(1'b1);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {trig_out, busy, result_out}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_runs = 0;
        m_fails = 0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (trig_out) n++;
        end
        chk("no_trig_after_reset", n, 0);
        v = rand256();
        do_run(7, 8, v, v, 0, '0, 0, 0);
        chk("run_after_reset", result_out, 32'h8100_0708);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
